// File: rtl/mem_mult_ctrl_pkg.sv
// rtl/mem_mult_ctrl_pkg.sv - shared constants and state encoding for the RAM-backed multiplier
package mem_mult_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADR_W_DEF  = 3;
    // One shift-add iteration per operand bit.
    localparam int MUL_CYCLES = DATA_W_DEF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        LD_A  = 3'd2,
        LD_B  = 3'd3,
        MUL   = 3'd4,
        WR_LO = 3'd5,
        WR_HI = 3'd6,
        DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/mem_mult_ctrl_shift_add_mult.sv
// rtl/mem_mult_ctrl_shift_add_mult.sv - sequential unsigned shift-add multiplier, one iteration per step
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture op_a/op_b, clear accumulator and step counter
//   op_a, op_b   unsigned operands (sampled on load)
//   step         perform one shift-add iteration
//   acc          running / final product
//   last         high while the final iteration is the one being stepped
module shift_add_mult
    import mem_mult_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STEPS  = MUL_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic                  step,
    output logic [2*DATA_W-1:0]   acc,
    output logic                  last
);

    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Multiplicand shifts left into the upper half; multiplier shifts right
    // so its LSB always selects whether this iteration adds.
    logic [2*DATA_W-1:0] mcand_q,  mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]    count_q,  count_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (load) begin
            mcand_d  = {{DATA_W{1'b0}}, op_a};
            mplier_d = op_b;
            acc_d    = '0;
            count_d  = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign acc  = acc_q;
    assign last = (count_q == CNT_W'(STEPS - 1));

endmodule

// File: rtl/mem_mult_ctrl.sv
// rtl/mem_mult_ctrl.sv - RAM initiator: read two operands, multiply, write 16-bit product back
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request pulse, sampled only in IDLE
//   a_adr, b_adr       operand addresses (latched on start)
//   p_adr              product low-byte address; high byte goes to p_adr+1 (wraps)
//   mem_w, mem_din     RAM write enable / write data
//   mem_adr            RAM address
//   mem_dout           RAM registered read data (one cycle after address)
//   busy               high in every state but IDLE
//   done               one-cycle completion pulse
//   product            last completed product, held until the next completion
module mem_mult_ctrl
    import mem_mult_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADR_W  = ADR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADR_W-1:0]      a_adr,
    input  logic [ADR_W-1:0]      b_adr,
    input  logic [ADR_W-1:0]      p_adr,
    output logic                  mem_w,
    output logic [DATA_W-1:0]     mem_din,
    output logic [ADR_W-1:0]      mem_adr,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    state_t                state_q, state_d;
    logic [ADR_W-1:0]      a_q, a_d;
    logic [ADR_W-1:0]      b_q, b_d;
    logic [ADR_W-1:0]      p_q, p_d;
    logic [DATA_W-1:0]     op_a_q, op_a_d;
    logic [2*DATA_W-1:0]   product_q, product_d;

    logic                  mul_load;
    logic                  mul_step;
    logic [2*DATA_W-1:0]   mul_acc;
    logic                  mul_last;

    shift_add_mult #(
        .DATA_W (DATA_W),
        .STEPS  (DATA_W)
    ) u_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mul_load),
        .op_a   (op_a_q),
        .op_b   (mem_dout),
        .step   (mul_step),
        .acc    (mul_acc),
        .last   (mul_last)
    );

    // RAM outputs are decoded from state only, so an asynchronous reset
    // drops mem_w immediately without waiting for a clock edge.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        op_a_d    = op_a_q;
        product_d = product_q;
        mem_w     = 1'b0;
        mem_din   = '0;
        mem_adr   = '0;
        busy      = 1'b1;
        done      = 1'b0;
        mul_load  = 1'b0;
        mul_step  = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    a_d     = a_adr;
                    b_d     = b_adr;
                    p_d     = p_adr;
                    state_d = RD_A;
                end
            end
            RD_A: begin
                mem_adr = a_q;
                state_d = LD_A;
            end
            LD_A: begin
                // Read data for A arrives now; B's read is issued in the same cycle.
                op_a_d  = mem_dout;
                mem_adr = b_q;
                state_d = LD_B;
            end
            LD_B: begin
                // mem_dout carries B here and feeds the multiplier load directly.
                mul_load = 1'b1;
                state_d  = MUL;
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                mem_w   = 1'b1;
                mem_adr = p_q;
                mem_din = mul_acc[DATA_W-1:0];
                state_d = WR_HI;
            end
            WR_HI: begin
                mem_w   = 1'b1;
                mem_adr = p_q + 1'b1;
                mem_din = mul_acc[2*DATA_W-1:DATA_W];
                state_d = DONE;
            end
            DONE: begin
                done      = 1'b1;
                product_d = mul_acc;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            op_a_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            p_q       <= p_d;
            op_a_q    <= op_a_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: doc/mem_mult_ctrl.md
Name: mem_mult_ctrl

Overview:
- Initiator FSM that drives the single-port 8x8 RAM interface (write enable, data in, address, registered read data).
- On `start` it reads two operands from RAM and multiplies them with a sequential shift-add unit. It writes the 16-bit product back as two bytes, low byte then high byte, and then pulses `done`.
- Sits between the top-level control logic and the RAM in the multiplier-with-memory design.

Parameters:
- DATA_W, 8, RAM word width and operand width. The product is 2*DATA_W wide.
- ADR_W, 3, RAM address width. The address space is 2**ADR_W words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- a_adr  in  ADR_W  address of operand A
- b_adr  in  ADR_W  address of operand B
- p_adr  in  ADR_W  address for the product low byte; the high byte goes to p_adr+1
- mem_w  out  1  RAM write enable
- mem_din  out  DATA_W  RAM write data
- mem_adr  out  ADR_W  RAM address
- mem_dout  in  DATA_W  RAM registered read data, valid one cycle after a read is issued
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- product  out  2*DATA_W  last computed product; holds until the next completion

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - mem_w=0, mem_din=0, mem_adr=0, busy=0, done=0, product=0.
  - All internal operand, accumulator and counter registers are cleared.
- RAM outputs are decoded combinationally from the state and the latched addresses. In any state where no read or write is defined, mem_w=0 and mem_adr=0.
- IDLE: on start=1, latch a_adr, b_adr and p_adr, then go to RD_A. start=0 keeps the FSM in IDLE.
- RD_A: mem_w=0, mem_adr=A. Go to LD_A.
- LD_A:
  - Capture mem_dout into op_a.
  - Drive mem_w=0, mem_adr=B.
  - Go to LD_B.
- LD_B: capture mem_dout into op_b, clear the accumulator, set count=0, go to MUL.
- MUL: one shift-add step per cycle for exactly DATA_W cycles (8 by default).
  - When count reaches DATA_W-1, go to WR_LO.
  - The arithmetic is unsigned; the 2*DATA_W result never overflows.
- WR_LO: mem_w=1, mem_adr=P, mem_din=acc[DATA_W-1:0]. Go to WR_HI.
- WR_HI:
  - mem_w=1, mem_adr=P+1 modulo 2**ADR_W, so p_adr=7 writes the high byte to address 0.
  - mem_din=acc[2*DATA_W-1:DATA_W].
  - Go to DONE.
- DONE: done=1 for this cycle only, product<=acc, go to IDLE. busy remains 1 in DONE.
- Latency: done is high in the 14th cycle after the edge that samples start (1+1+1+8+1+1+1 states, default parameters). A new start is accepted in the first IDLE cycle after DONE.
- start while busy is ignored and not queued. Changes on a_adr, b_adr or p_adr after the start edge have no effect on the operation in progress.
- Aliasing:
  - a_adr==b_adr is legal; the result is the square.
  - p_adr or p_adr+1 may equal a_adr or b_adr. Operands are captured before any write, so the product overwrites the operands correctly.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_w drops to 0 asynchronously. A partial write, such as the low byte only, is left in RAM. product clears to 0.
- Operand 0 on either side gives product 0, written as two 0x00 bytes; all MUL cycles still execute, so latency is fixed.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, RD_A, LD_A, LD_B, MUL, WR_LO, WR_HI, DONE (3-bit);
  - DATA_W / ADR_W defaults;
  - the MUL cycle count constant.
- One sub-module: shift_add_mult.
  - Ports: clk, rst_n, load, op_a, op_b, step, acc, last.
  - mem_mult_ctrl keeps the FSM and the RAM sequencing; shift_add_mult performs one shift-add iteration per step.

Test Plan:
- Preload RAM[0]=0x05, RAM[1]=0x07; start with a=0, b=1, p=2 -> RAM[2]=0x23, RAM[3]=0x00, product=0x0023, done exactly 14 cycles after start, busy high for those 14 cycles.
- RAM[4]=0xFF, a=b=4, p=7 -> RAM[7]=0x01, RAM[0]=0xFE (address wrap), product=0xFE01.
- RAM[5]=0x00, RAM[6]=0x9C, a=5, b=6, p=5 -> RAM[5]=0x00, RAM[6]=0x00 (operands overwritten), product=0x0000, latency still 14.
- Pulse start again at cycle 5 of a running operation with different addresses -> ignored; one done only; the second op's addresses are never driven.
- Assert rst_n=0 during WR_HI -> mem_w=0 before the next edge; low byte written, high byte not; busy=0, product=0; a following start completes normally (RAM[2]=0x0C, RAM[3]=0x00 for RAM[0]=0x03, RAM[1]=0x04).
- Back-to-back ops: start in the first IDLE cycle after DONE -> accepted; two done pulses exactly 15 cycles apart, both products correct.
